// File: rtl/msx_mouse_port.sv
// PS/2 mouse packets to the MSX joystick-port mouse protocol: accumulates
// saturated deltas and serves them as four strobe-advanced nibbles.
module msx_mouse_port #(
    parameter int TIMEOUT = 32000,
    parameter int CNT_W   = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic        strobe,
    output logic [5:0]  data,
    output logic        frame_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               tog_q, tog_d;
    logic               strobe_q, strobe_d;
    logic signed [7:0]  acc_x_q, acc_x_d;
    logic signed [7:0]  acc_y_q, acc_y_d;
    logic        [7:0]  lat_x_q, lat_x_d;
    logic        [7:0]  lat_y_q, lat_y_d;
    logic        [1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic        [1:0]  btn_q, btn_d;
    logic        [5:0]  data_q, data_d;
    logic               busy_q, busy_d;

    logic               pkt;
    logic               edge_seen;
    logic               do_latch;
    logic signed [8:0]  dx, dy;
    logic signed [10:0] mx, my;
    logic signed [7:0]  base_x, base_y;
    logic        [3:0]  nib;

    // Clamp an extended sum into the signed 8-bit range instead of wrapping.
    function automatic logic signed [7:0] sat8(input logic signed [10:0] v);
        if (v > 11'sd127)
            return 8'sd127;
        else if (v < -11'sd128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

    assign pkt       = ps2_mouse[24] ^ tog_q;
    assign edge_seen = strobe ^ strobe_q;
    assign do_latch  = edge_seen && ((state_q == ST_IDLE) || (idx_q == 2'd3));

    assign dx = {ps2_mouse[4], ps2_mouse[15:8]};
    assign dy = {ps2_mouse[5], ps2_mouse[23:16]};
    // MSX reports rightward motion as negative X; Y keeps the PS/2 sign.
    assign mx = -{{2{dx[8]}}, dx};
    assign my = {{2{dy[8]}}, dy};

    // A latch empties the accumulator, so a packet in that cycle starts fresh.
    assign base_x = do_latch ? 8'sd0 : acc_x_q;
    assign base_y = do_latch ? 8'sd0 : acc_y_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        tog_d    = ps2_mouse[24];
        strobe_d = strobe;
        lat_x_d  = lat_x_q;
        lat_y_d  = lat_y_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        btn_d    = btn_q;

        if (do_latch) begin
            lat_x_d = acc_x_q;
            lat_y_d = acc_y_q;
            idx_d   = 2'd0;
            cnt_d   = '0;
            state_d = ST_FRAME;
        end else if (edge_seen) begin
            idx_d = idx_q + 2'd1;
            cnt_d = '0;
        end else if (state_q == ST_FRAME) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (pkt) begin
            acc_x_d = sat8(11'(base_x) + mx);
            acc_y_d = sat8(11'(base_y) + my);
            btn_d   = ps2_mouse[1:0];
        end else begin
            acc_x_d = base_x;
            acc_y_d = base_y;
        end

        // idx is forced to 0 in IDLE, so IDLE naturally shows latX[7:4].
        case (idx_d)
            2'd0:    nib = lat_x_d[7:4];
            2'd1:    nib = lat_x_d[3:0];
            2'd2:    nib = lat_y_d[7:4];
            default: nib = lat_y_d[3:0];
        endcase

        data_d = {~btn_d[1], ~btn_d[0], nib};
        busy_d = (state_d == ST_FRAME);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tog_q    <= ps2_mouse[24];
            strobe_q <= strobe;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            lat_x_q  <= '0;
            lat_y_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            btn_q    <= '0;
            data_q   <= 6'b110000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tog_q    <= tog_d;
            strobe_q <= strobe_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            lat_x_q  <= lat_x_d;
            lat_y_q  <= lat_y_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            btn_q    <= btn_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign data       = data_q;
    assign frame_busy = busy_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Scoreboard bench for msx_mouse_port: expected nibbles are queued when
// stimulus is driven and popped as each strobe edge produces output.
module tb_msx_mouse_port;

    localparam int TIMEOUT = 32000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] ps2_mouse = '0;
    logic        strobe = 1'b0;
    logic [5:0]  data;
    logic        frame_busy;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    msx_mouse_port #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_mouse  (ps2_mouse),
        .strobe     (strobe),
        .data       (data),
        .frame_busy (frame_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] flags);
        ps2_mouse = {~ps2_mouse[24], y, x, flags};
        tick();
    endtask

    // Toggle the strobe, wait one clock and pop the matching expectation.
    task automatic edge_pop(output logic [3:0] got, output logic [3:0] exp);
        strobe = ~strobe;
        tick();
        got = data[3:0];
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    endtask

    task automatic test_reset();
        logic [3:0] got, exp;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (data !== 6'b110000) begin
            failures++;
            $display("FAIL reset_data got=%b exp=110000", data);
        end
        checks++;
        if (frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", frame_busy);
        end
        reset_n = 1'b1;
        tick();
        repeat (4) exp_q.push_back(4'h0);
        for (int i = 0; i < 4; i++) begin
            edge_pop(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_nibble%0d got=%h exp=%h", i, got, exp);
            end
            if (i == 0) begin
                checks++;
                if (frame_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL first_edge_busy got=%b exp=1", frame_busy);
                end
            end
        end
    endtask

    task automatic test_packet();
        logic [3:0] got, exp;
        send_pkt(8'h05, 8'h03, 8'h00);
        exp_q.push_back(4'hF); exp_q.push_back(4'hB);
        exp_q.push_back(4'h0); exp_q.push_back(4'h3);
        repeat (4) exp_q.push_back(4'h0);
        for (int i = 0; i < 8; i++) begin
            edge_pop(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL packet_nibble%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] got, exp;
        repeat (3) send_pkt(8'h64, 8'h00, 8'h00);
        exp_q.push_back(4'h8); exp_q.push_back(4'h0);
        exp_q.push_back(4'h0); exp_q.push_back(4'h0);
        for (int i = 0; i < 4; i++) begin
            edge_pop(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sat_neg_nibble%0d got=%h exp=%h", i, got, exp);
            end
        end
        repeat (3) send_pkt(8'h9C, 8'h00, 8'h10);
        exp_q.push_back(4'h7); exp_q.push_back(4'hF);
        exp_q.push_back(4'h0); exp_q.push_back(4'h0);
        for (int i = 0; i < 4; i++) begin
            edge_pop(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sat_pos_nibble%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] got, exp;
        int n;
        send_pkt(8'h30, 8'h00, 8'h00);
        exp_q.push_back(4'hD); exp_q.push_back(4'h0);
        for (int i = 0; i < 2; i++) begin
            edge_pop(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL timeout_nibble%0d got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if (frame_busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_busy_before got=%b exp=1", frame_busy);
        end
        send_pkt(8'h10, 8'h00, 8'h00);
        n = 1;
        while (frame_busy === 1'b1 && n < TIMEOUT + 50) begin
            tick();
            n++;
        end
        checks++;
        if (frame_busy !== 1'b0 || n < TIMEOUT - 2 || n > TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_expiry busy=%b cycles=%0d exp_cycles~%0d", frame_busy, n, TIMEOUT);
        end
        checks++;
        if (data[3:0] !== 4'hD) begin
            failures++;
            $display("FAIL idle_nibble got=%h exp=d", data[3:0]);
        end
        exp_q.push_back(4'hF);
        edge_pop(got, exp);
        checks++;
        if (got !== exp || frame_busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_relatch got=%h/%b exp=%h/1", got, frame_busy, exp);
        end
    endtask

    task automatic test_same_cycle();
        logic [3:0] got, exp;
        send_pkt(8'h20, 8'h00, 8'h00);
        repeat (3) exp_q.push_back(4'h0);
        exp_q.push_back(4'hE);
        repeat (3) exp_q.push_back(4'h0);
        exp_q.push_back(4'h0); exp_q.push_back(4'h2);
        exp_q.push_back(4'h0); exp_q.push_back(4'h0);
        for (int i = 0; i < 11; i++) begin
            if (i == 3) begin
                ps2_mouse = {~ps2_mouse[24], 8'h00, 8'hFE, 8'h10};
                strobe = ~strobe;
                tick();
                got = data[3:0];
                exp = exp_q.pop_front();
            end else begin
                edge_pop(got, exp);
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL same_cycle_nibble%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_buttons_reset();
        logic [3:0] got, exp;
        checks++;
        if (data[5:4] !== 2'b11) begin
            failures++;
            $display("FAIL buttons_released got=%b exp=11", data[5:4]);
        end
        send_pkt(8'h00, 8'h00, 8'h01);
        checks++;
        if (data[5:4] !== 2'b10) begin
            failures++;
            $display("FAIL left_button got=%b exp=10", data[5:4]);
        end
        send_pkt(8'h70, 8'h00, 8'h01);
        exp_q.push_back(4'h9);
        edge_pop(got, exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL pre_reset_nibble got=%h exp=%h", got, exp);
        end
        send_pkt(8'h40, 8'h00, 8'h00);
        reset_n = 1'b0;
        tick();
        checks++;
        if (data !== 6'b110000 || frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_frame_reset got=%b/%b exp=110000/0", data, frame_busy);
        end
        reset_n = 1'b1;
        tick();
        repeat (4) exp_q.push_back(4'h0);
        for (int i = 0; i < 4; i++) begin
            edge_pop(got, exp);
            checks++;
            if (got !== exp || data[5:4] !== 2'b11) begin
                failures++;
                $display("FAIL post_reset_nibble%0d got=%h/%b exp=%h/11", i, got, data[5:4], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_saturation();
        test_timeout();
        test_same_cycle();
        test_buttons_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
